// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, fetches from word-indexed
// instruction memory and fills the IF/ID register; parks in HALT past end of program.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 20,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] PC,
  input  logic [31:0] instruction,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_p0, pc_d;
  logic [31:0] ifid_pc_p1, ifid_pc_d;
  logic [31:0] ifid_pc4_p1, ifid_pc4_d;
  logic [31:0] ifid_instr_p1, ifid_instr_d;
  logic        vld_p1, vld_d;
  logic        in_range;
  logic        unused_target_lsbs;

  // Targets are word-aligned by construction; the byte offset is discarded.
  assign unused_target_lsbs = ^redirect_target[1:0];

  assign in_range = (pc_p0 < PC_LIMIT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_p0;
    ifid_pc_d    = ifid_pc_p1;
    ifid_pc4_d   = ifid_pc4_p1;
    ifid_instr_d = ifid_instr_p1;
    vld_d        = vld_p1;
    if (redirect) begin
      pc_d         = {redirect_target[31:2], 2'b00};
      ifid_pc_d    = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_instr_d = NOP_INSTR;
      vld_d        = 1'b0;
      state_d      = RUN;
    end else if (!stall) begin
      if (state_q == RUN && in_range) begin
        ifid_pc_d    = pc_p0;
        ifid_pc4_d   = pc_p0 + 32'd4;
        ifid_instr_d = instruction;
        vld_d        = 1'b1;
        pc_d         = pc_p0 + 32'd4;
      end else begin
        // Past the end of program (or already halted): PC parks, bubbles flow.
        ifid_pc_d    = 32'h0;
        ifid_pc4_d   = 32'h0;
        ifid_instr_d = NOP_INSTR;
        vld_d        = 1'b0;
        state_d      = HALT;
      end
    end
  end

  // Stage p0 -> p1: PC register and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_p0         <= RESET_PC;
      ifid_pc_p1    <= 32'h0;
      ifid_pc4_p1   <= 32'h0;
      ifid_instr_p1 <= NOP_INSTR;
      vld_p1        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_p0         <= pc_d;
      ifid_pc_p1    <= ifid_pc_d;
      ifid_pc4_p1   <= ifid_pc4_d;
      ifid_instr_p1 <= ifid_instr_d;
      vld_p1        <= vld_d;
    end
  end

  assign PC            = pc_p0;
  assign ifid_pc       = ifid_pc_p1;
  assign ifid_pc_plus4 = ifid_pc4_p1;
  assign ifid_instr    = ifid_instr_p1;
  assign ifid_valid    = vld_p1;
  assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, end-of-memory sequences and
// randomized stall/redirect/reset traffic against a spec-level model.
module tb_fetch_stage;

  localparam int WORDS = 20;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_target, PC, instruction;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
  logic        ifid_valid, halted;

  logic [31:0] mem [WORDS];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the IF stage should hold after each edge.
  logic [31:0] m_pc, m_ipc, m_instr;
  logic        m_valid, m_halt, m_pc_known;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .PC(PC), .instruction(instruction),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  assign instruction = (PC < 32'(WORDS * 4)) ? mem[PC[31:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic d, input logic [31:0] t);
    if (!r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_halt = 1'b0; m_pc_known = 1'b1;
    end else if (d) begin
      m_pc = t & 32'hFFFF_FFFC; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_halt = 1'b0; m_pc_known = 1'b1;
    end else if (s) begin
      // everything holds
    end else if (!m_halt && m_pc < WORDS * 4) begin
      m_ipc = m_pc; m_instr = mem[m_pc / 4]; m_valid = 1'b1; m_pc_known = 1'b1;
      m_pc = m_pc + 4;
    end else begin
      m_instr = NOP; m_valid = 1'b0; m_halt = 1'b1; m_pc_known = 1'b0;
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst_n = r; stall = s; redirect = d; redirect_target = t;
    model_step(r, s, d, t);
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".pc"}, PC, m_pc);
    chk({tag, ".instr"}, ifid_instr, m_instr);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    if (m_pc_known) begin
      chk({tag, ".ifid_pc"}, ifid_pc, m_ipc);
      chk({tag, ".ifid_pc4"}, ifid_pc_plus4, m_valid ? m_ipc + 32'd4 : 32'h0);
    end
  endtask

  typedef struct {
    logic        r, s, d;
    logic [31:0] tgt, pc, ipc, instr;
    logic        vld, hlt;
  } vec_t;

  vec_t vt [15];

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    mem[0] = 32'h3990_0313;
    mem[1] = 32'h0060_2223;
    for (int i = 2; i < WORDS; i++) mem[i] = $urandom;

    //          r     s     d     tgt           pc            ifid_pc       instr    vld   hlt
    vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        NOP,     1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        mem[0],  1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        mem[1],  1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        mem[1],  1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        mem[1],  1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        mem[1],  1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        mem[2],  1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h10,       32'hC,        mem[3],  1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h34,       32'h34,       32'h0,        NOP,     1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h38,       32'h34,       mem[13], 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b1, 32'h26,       32'h24,       32'h0,        NOP,     1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h28,       32'h24,       mem[9],  1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h2C,       32'h28,       mem[10], 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h40,       32'h0,        32'h0,        NOP,     1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        mem[0],  1'b1, 1'b0};

    #2;
    for (int i = 0; i < 15; i++) begin
      cycle(vt[i].r, vt[i].s, vt[i].d, vt[i].tgt);
      chk($sformatf("vec%0d.pc", i), PC, vt[i].pc);
      chk($sformatf("vec%0d.ifid_pc", i), ifid_pc, vt[i].ipc);
      chk($sformatf("vec%0d.ifid_pc4", i), ifid_pc_plus4, vt[i].vld ? vt[i].ipc + 32'd4 : 32'h0);
      chk($sformatf("vec%0d.instr", i), ifid_instr, vt[i].instr);
      chk($sformatf("vec%0d.valid", i), 32'(ifid_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d.halted", i), 32'(halted), 32'(vt[i].hlt));
    end

    // Free-run to the end of program memory.
    for (int i = 0; i < 40 && PC != 32'd80; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      model_check("run");
    end
    chk("end.pc_reached", PC, 32'd80);
    chk("end.halted_before", 32'(halted), 32'h0);
    chk("end.last_ifid_pc", ifid_pc, 32'd76);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("halt%0d.pc", i), PC, 32'd80);
      chk($sformatf("halt%0d.halted", i), 32'(halted), 32'h1);
      chk($sformatf("halt%0d.valid", i), 32'(ifid_valid), 32'h0);
      chk($sformatf("halt%0d.instr", i), ifid_instr, NOP);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("halt_stall.halted", 32'(halted), 32'h1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    chk("unhalt.pc", PC, 32'h0);
    chk("unhalt.halted", 32'(halted), 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("refetch.instr", ifid_instr, mem[0]);
    chk("refetch.valid", 32'(ifid_valid), 32'h1);
    chk("refetch.pc", PC, 32'h4);

    // Redirect to an out-of-range target: RUN first, HALT on the next normal edge.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_1003);
    chk("oor.pc", PC, 32'h1000);
    chk("oor.halted_first", 32'(halted), 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("oor.pc_hold", PC, 32'h1000);
    chk("oor.halted", 32'(halted), 32'h1);
    chk("oor.valid", 32'(ifid_valid), 32'h0);
    chk("oor.instr", ifid_instr, NOP);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic        r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 25);
      d = ($urandom_range(0, 99) < 8);
      t = ($urandom_range(0, 9) == 0) ? $urandom
                                       : 32'($urandom_range(0, WORDS + 3) * 4 + $urandom_range(0, 3));
      cycle(r, s, d, t);
      model_check($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
